// File: rtl/player_controller.sv
// Debounced buttons drive a per-frame horizontal move and a GROUND/RISE/FALL jump FSM.
// Latency: position and pos_valid_o appear 1 clock after an accepted tick; there is no backpressure, and ticks with game_en_i=0 are dropped.
module player_controller #(
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int PLAYER_W        = 32,
    parameter int PLAYER_H        = 32,
    parameter int STEP            = 4,
    parameter int JUMP_FRAMES     = 16,
    parameter int GROUND_Y        = 416,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int POS_W           = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             btn_left_i,
    input  logic             btn_right_i,
    input  logic             btn_jump_i,
    input  logic             frame_tick_i,
    input  logic             game_en_i,
    output logic [POS_W-1:0] player_x_o,
    output logic [POS_W-1:0] player_y_o,
    output logic             airborne_o,
    output logic             pos_valid_o
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RC_W     = (JUMP_FRAMES > 1) ? $clog2(JUMP_FRAMES) : 1;
    localparam int GROUND_C = (GROUND_Y <= SCREEN_H - PLAYER_H) ? GROUND_Y : SCREEN_H - PLAYER_H;

    localparam logic [POS_W:0]   X_MAX    = (POS_W+1)'(SCREEN_W - PLAYER_W);
    localparam logic [POS_W:0]   STEP_E   = (POS_W+1)'(STEP);
    localparam logic [POS_W:0]   GROUND_E = (POS_W+1)'(GROUND_C);
    localparam logic [POS_W-1:0] X_RESET  = POS_W'((SCREEN_W - PLAYER_W) / 2);
    localparam logic [POS_W-1:0] Y_RESET  = POS_W'(GROUND_C);

    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_JUMP  = 2;

    typedef enum logic [1:0] {
        ST_GROUND,
        ST_RISE,
        ST_FALL
    } state_t;

    logic [2:0]           sync1_q, sync1_d;
    logic [2:0]           sync2_q, sync2_d;
    logic [2:0]           db_q, db_d;
    logic [2:0][DB_W-1:0] cnt_q, cnt_d;
    logic                 jump_rise;

    state_t               state_q, state_d;
    logic [RC_W-1:0]      rise_cnt_q, rise_cnt_d;
    logic                 jump_pend_q, jump_pend_d;
    logic [POS_W-1:0]     x_q, x_d;
    logic [POS_W-1:0]     y_q, y_d;
    logic                 airborne_q, airborne_d;
    logic                 pos_valid_q, pos_valid_d;

    logic                 acc;
    logic [POS_W:0]       x_dn, x_up, y_dn, y_up;

    // Counter runs only while the synced level disagrees with the accepted one.
    always_comb begin
        sync1_d   = {btn_jump_i, btn_right_i, btn_left_i};
        sync2_d   = sync1_q;
        db_d      = db_q;
        cnt_d     = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i]  = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
        jump_rise = db_d[B_JUMP] & ~db_q[B_JUMP];
    end

    always_comb begin
        acc         = frame_tick_i & game_en_i;
        x_d         = x_q;
        y_d         = y_q;
        state_d     = state_q;
        rise_cnt_d  = rise_cnt_q;
        jump_pend_d = jump_pend_q;
        pos_valid_d = acc;
        x_dn        = {1'b0, x_q} - STEP_E;
        x_up        = {1'b0, x_q} + STEP_E;
        y_dn        = {1'b0, y_q} - STEP_E;
        y_up        = {1'b0, y_q} + STEP_E;

        if (acc) begin
            jump_pend_d = 1'b0;

            if (db_q[B_LEFT] && !db_q[B_RIGHT]) begin
                x_d = ({1'b0, x_q} < STEP_E) ? '0 : x_dn[POS_W-1:0];
            end else if (db_q[B_RIGHT] && !db_q[B_LEFT]) begin
                x_d = (x_up > X_MAX) ? X_MAX[POS_W-1:0] : x_up[POS_W-1:0];
            end

            case (state_q)
                ST_GROUND: begin
                    if (jump_pend_q) begin
                        state_d    = ST_RISE;
                        rise_cnt_d = '0;
                    end
                end
                ST_RISE: begin
                    y_d        = ({1'b0, y_q} < STEP_E) ? '0 : y_dn[POS_W-1:0];
                    rise_cnt_d = rise_cnt_q + RC_W'(1);
                    if (rise_cnt_q == RC_W'(JUMP_FRAMES - 1)) begin
                        state_d = ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (y_up >= GROUND_E) begin
                        y_d     = Y_RESET;
                        state_d = ST_GROUND;
                    end else begin
                        y_d = y_up[POS_W-1:0];
                    end
                end
                default: state_d = ST_GROUND;
            endcase
        end

        // A press landing on the same clock as a tick belongs to the next tick.
        if (jump_rise) begin
            jump_pend_d = 1'b1;
        end
        airborne_d = (state_d != ST_GROUND);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            cnt_q       <= '0;
            state_q     <= ST_GROUND;
            rise_cnt_q  <= '0;
            jump_pend_q <= 1'b0;
            x_q         <= X_RESET;
            y_q         <= Y_RESET;
            airborne_q  <= 1'b0;
            pos_valid_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            rise_cnt_q  <= rise_cnt_d;
            jump_pend_q <= jump_pend_d;
            x_q         <= x_d;
            y_q         <= y_d;
            airborne_q  <= airborne_d;
            pos_valid_q <= pos_valid_d;
        end
    end

    assign player_x_o  = x_q;
    assign player_y_o  = y_q;
    assign airborne_o  = airborne_q;
    assign pos_valid_o = pos_valid_q;

endmodule
